// File: rtl/sr_ff_bank.sv
// Multi-channel SR/JK/D/T flip-flop bank with forbidden-SR detection and event counting.
// Optional macro SR_SET_DOMINANT_EN makes SR S=R=1 set the channel instead of holding it.
module sr_ff_bank #(
  parameter int unsigned     WIDTH     = 8,
  parameter int unsigned     CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_en,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_s,
  input  logic [WIDTH-1:0] in_r,
  input  logic             in_clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             illegal,
  output logic [WIDTH-1:0] illegal_mask,
  output logic             err_sticky,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {ModeSr, ModeJk, ModeD, ModeT} mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             illegal_q, illegal_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign mode = mode_e'(in_mode);

  always_comb begin
    q_d    = q_q;
    mask_d = '0;
    if (in_en) begin
      unique case (mode)
        ModeSr: begin
          mask_d = in_s & in_r;
`ifdef SR_SET_DOMINANT_EN
          q_d = in_s | (q_q & ~in_r);
`else
          // Forbidden channels (S=R=1) keep their previous value.
          q_d = (in_s & ~in_r) | (q_q & ~in_r & ~in_s) | (q_q & in_s & in_r);
`endif
        end
        ModeJk: q_d = (in_s & ~q_q) | (~in_r & q_q);
        ModeD:  q_d = in_s;
        ModeT:  q_d = q_q ^ in_s;
        default: q_d = q_q;
      endcase
    end
  end

  always_comb begin
    illegal_d = |mask_d;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    if (illegal_d) begin
      // A new event outranks a simultaneous clear.
      sticky_d = 1'b1;
      if (in_clr_err) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (in_clr_err) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      q_q       <= RESET_VAL;
      mask_q    <= '0;
      illegal_q <= 1'b0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      q_q       <= q_d;
      mask_q    <= mask_d;
      illegal_q <= illegal_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
    end
  end

  assign q            = q_q;
  assign q_n          = ~q_q;
  assign illegal      = illegal_q;
  assign illegal_mask = mask_q;
  assign err_sticky   = sticky_q;
  assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed self-checking bench for sr_ff_bank; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_sr_ff_bank;

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [1:0] mode;
  logic [7:0] s, r;

  logic [7:0] q, q_n, mask;
  logic       illegal, sticky;
  logic [7:0] cnt;

  logic [7:0] sq, sq_n, smask;
  logic       sillegal, ssticky;
  logic [1:0] scnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sr_ff_bank #(.WIDTH(8), .CNT_W(8), .RESET_VAL(8'hA5)) dut (
    .in_clk(clk), .in_rst(rst), .in_en(en), .in_mode(mode), .in_s(s), .in_r(r),
    .in_clr_err(clr), .q(q), .q_n(q_n), .illegal(illegal), .illegal_mask(mask),
    .err_sticky(sticky), .illegal_cnt(cnt)
  );

  sr_ff_bank #(.WIDTH(8), .CNT_W(2), .RESET_VAL(8'hA5)) dut_sat (
    .in_clk(clk), .in_rst(rst), .in_en(en), .in_mode(mode), .in_s(s), .in_r(r),
    .in_clr_err(clr), .q(sq), .q_n(sq_n), .illegal(sillegal), .illegal_mask(smask),
    .err_sticky(ssticky), .illegal_cnt(scnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic e, input logic [7:0] sv,
                       input logic [7:0] rv, input logic c);
    mode = m; en = e; s = sv; r = rv; clr = c;
    tick();
  endtask

  task automatic chk_flags(input string tag, input logic il, input logic [7:0] mk,
                           input logic st, input logic [7:0] ct);
    chk({tag, "_illegal"}, 32'(illegal), 32'(il));
    chk({tag, "_mask"}, 32'(mask), 32'(mk));
    chk({tag, "_sticky"}, 32'(sticky), 32'(st));
    chk({tag, "_cnt"}, 32'(cnt), 32'(ct));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b1; mode = 2'b00; s = 8'hFF; r = 8'hFF;
    tick();
    rst = 1'b0;
    chk("rst_q", 32'(q), 32'hA5);
    chk("rst_qn", 32'(q_n), 32'h5A);
    chk_flags("rst", 1'b0, 8'h00, 1'b0, 8'd0);

    // SR sequence on channel 0 (q[0] starts at 1)
    drive(2'b00, 1'b1, 8'h00, 8'h00, 1'b0);
    chk("sr_00", 32'(q), 32'hA5);
    drive(2'b00, 1'b1, 8'h00, 8'h01, 1'b0);
    chk("sr_01", 32'(q), 32'hA4);
    chk_flags("sr_01", 1'b0, 8'h00, 1'b0, 8'd0);
    drive(2'b00, 1'b1, 8'h01, 8'h00, 1'b0);
    chk("sr_10", 32'(q), 32'hA5);
    drive(2'b00, 1'b1, 8'h01, 8'h01, 1'b0);
    chk("sr_11", 32'(q), 32'hA5);
    chk_flags("sr_11", 1'b1, 8'h01, 1'b1, 8'd1);
    drive(2'b00, 1'b1, 8'h00, 8'h00, 1'b0);
    chk_flags("sr_after", 1'b0, 8'h00, 1'b1, 8'd1);

    // Clear q via D mode, then JK toggle
    drive(2'b10, 1'b1, 8'h00, 8'h00, 1'b0);
    chk("d_zero", 32'(q), 32'h00);
    drive(2'b01, 1'b1, 8'hFF, 8'hFF, 1'b0);
    chk("jk_1", 32'(q), 32'hFF);
    drive(2'b01, 1'b1, 8'hFF, 8'hFF, 1'b0);
    chk("jk_2", 32'(q), 32'h00);
    drive(2'b01, 1'b1, 8'hFF, 8'hFF, 1'b0);
    chk("jk_3", 32'(q), 32'hFF);
    chk_flags("jk", 1'b0, 8'h00, 1'b1, 8'd1);
    drive(2'b01, 1'b1, 8'hF0, 8'h0F, 1'b0);
    chk("jk_setclr", 32'(q), 32'hF0);

    // D, T, then enable low
    drive(2'b10, 1'b1, 8'h3C, 8'hFF, 1'b0);
    chk("d_3c", 32'(q), 32'h3C);
    drive(2'b11, 1'b1, 8'h0F, 8'hFF, 1'b0);
    chk("t_0f", 32'(q), 32'h33);
    chk("t_qn", 32'(q_n), 32'hCC);
    drive(2'b11, 1'b0, 8'hFF, 8'h00, 1'b0);
    chk("en0_t", 32'(q), 32'h33);
    drive(2'b00, 1'b0, 8'h33, 8'h33, 1'b0);
    chk("en0_sr", 32'(q), 32'h33);
    chk_flags("en0", 1'b0, 8'h00, 1'b1, 8'd1);

    // Clear alone, then clear colliding with an event
    drive(2'b10, 1'b1, 8'h33, 8'h00, 1'b1);
    chk_flags("clr", 1'b0, 8'h00, 1'b0, 8'd0);
    chk("clr_scnt", 32'(scnt), 32'd0);
    drive(2'b00, 1'b1, 8'h33, 8'h33, 1'b1);
    chk("coll_q", 32'(q), 32'h33);
    chk_flags("coll", 1'b1, 8'h33, 1'b1, 8'd1);

    // Saturation of the 2-bit counter; multi-channel events count once
    drive(2'b10, 1'b1, 8'h33, 8'h00, 1'b1);
    chk("sat_clr", 32'(scnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, 1'b1, 8'h33, 8'h33, 1'b0);
      chk($sformatf("sat_%0d", i), 32'(scnt), (i < 3) ? 32'(i + 1) : 32'd3);
      chk($sformatf("cnt_%0d", i), 32'(cnt), 32'(i + 1));
      chk($sformatf("smask_%0d", i), 32'(smask), 32'h33);
    end
    chk("sat_sticky", 32'(ssticky), 32'd1);

    // Mid-operation reset wipes pending event
    rst = 1'b1;
    drive(2'b00, 1'b1, 8'hFF, 8'hFF, 1'b1);
    rst = 1'b0;
    chk("mid_rst_q", 32'(q), 32'hA5);
    chk_flags("mid_rst", 1'b0, 8'h00, 1'b0, 8'd0);
    chk("mid_rst_scnt", 32'(scnt), 32'd0);
    drive(2'b00, 1'b1, 8'h00, 8'h00, 1'b0);
    chk_flags("post_rst", 1'b0, 8'h00, 1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
- Parametrised multi-channel clocked flip-flop bank. It is the synchronous, multi-bit successor to the single SR storage element.
- Each of WIDTH channels acts as an SR, JK, D or T flip-flop, selected at run time by a shared mode input.
- It detects the forbidden SR condition (S=R=1) and counts occurrences.
- It is used as a general control/status storage primitive in the sequential design set.

Parameters:
- WIDTH, 8, number of independent flip-flop channels.
- CNT_W, 8, width of the saturating illegal-event counter.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- in_clk  input  1  clock; all state updates on rising edge.
- in_rst  input  1  synchronous active-high reset.
- in_en  input  1  global update enable; 0 = all channels hold.
- in_mode  input  2  00 SR, 01 JK, 10 D, 11 T; shared by all channels.
- in_s  input  WIDTH  S (SR), J (JK), D (D), T (T) per channel.
- in_r  input  WIDTH  R (SR), K (JK); ignored in D and T modes.
- in_clr_err  input  1  clears err_sticky and illegal_cnt.
- q  output  WIDTH  registered channel state.
- q_n  output  WIDTH  bitwise inverse of q (combinational from q).
- illegal  output  1  registered pulse: previous cycle had an SR-mode S=R=1 on any channel with in_en=1.
- illegal_mask  output  WIDTH  registered; channels that were illegal in that cycle.
- err_sticky  output  1  set by any illegal event, held until clear or reset.
- illegal_cnt  output  CNT_W  count of illegal cycles, saturating at all-ones.

Behaviour:
- Reset (in_rst=1 at clock edge):
  - q=RESET_VAL.
  - illegal=0, illegal_mask=0, err_sticky=0, illegal_cnt=0.
  - Reset overrides in_en and in_clr_err.
- Latency and enable:
  - q updates one clock after inputs are sampled; no combinational path from in_s/in_r to q.
  - in_en=0: q holds; illegal and illegal_mask are driven to 0 next cycle; counter and sticky hold.
- Per-channel next state when in_en=1:
  - SR mode: S=0,R=0 hold; S=1,R=0 set 1; S=0,R=1 clear 0; S=1,R=1 hold, flagged illegal.
  - JK mode: J=0,K=0 hold; J=1,K=0 set 1; J=0,K=1 clear 0; J=1,K=1 toggle. Never illegal.
  - D mode: q = in_s.
  - T mode: in_s=1 toggles; in_s=0 holds.
- Illegal detection:
  - Only in SR mode with in_en=1. Illegal and legal channels update independently in the same cycle.
  - illegal_mask = in_s & in_r; illegal = |illegal_mask. Both registered, one-cycle latency.
- Counter and sticky flag:
  - illegal_cnt increments by exactly 1 per illegal cycle, regardless of how many channels are illegal; it saturates and never wraps.
  - err_sticky is set on the same edge that illegal is asserted.
  - Simultaneous in_clr_err and a new illegal event: the event wins (cnt=1, err_sticky=1).
  - in_clr_err without an event: cnt=0, err_sticky=0 next cycle.
- Mode changes:
  - A mode change takes effect on the same edge it is sampled. No internal mode state.
  - q carries over unchanged across mode switches.
- Mid-operation reset: all outputs return to their reset values on the next edge; no pending events survive.

Optional Feature:
- Macro: SR_SET_DOMINANT_EN.
- Defined: SR mode S=R=1 sets the channel to 1 (set-dominant). The illegal flag, mask, counter and sticky flag are still asserted.
- Not defined: S=R=1 holds the channel, as above.
- JK, D and T behaviour is unaffected either way.

Test Plan:
- Reset: RESET_VAL=8'hA5, in_rst=1 one cycle → q=8'hA5, q_n=8'h5A, illegal=0, illegal_cnt=0, err_sticky=0.
- SR sequence on channel 0, mode=00, en=1: S/R = 0/0, 0/1, 1/0, 1/1 → q[0] = hold, 0, 1, then 1 (hold) with illegal=1 and illegal_mask=8'h01 one cycle later, illegal_cnt=1. With SR_SET_DOMINANT_EN, a start of q[0]=0 gives 1/1 → 1.
- JK toggle: mode=01, J=K=8'hFF, from q=8'h00 for 3 cycles → q = 8'hFF, 8'h00, 8'hFF; illegal stays 0.
- D/T/en: mode=10, in_s=8'h3C → q=8'h3C. Then mode=11, in_s=8'h0F → q=8'h33. Then en=0 with in_s=8'hFF → q stays 8'h33.
- Counter saturation: CNT_W=2, 5 consecutive SR illegal cycles → illegal_cnt = 1, 2, 3, 3, 3.
- Clear collision: in_clr_err=1 alone → cnt=0, sticky=0. Then in_clr_err=1 together with an illegal event → cnt=1, sticky=1.
